// File: rtl/rule_dram_loader_pkg.sv
// Shared constants and FSM state type for the rule memory write path.
package rule_mem_pkg;

   localparam int RULE_ADDR_W  = 15;
   localparam int RULE_ENTRY_W = 4;
   localparam int RULE_WORD_W  = 32;
   localparam int RULE_NIB     = RULE_WORD_W / RULE_ENTRY_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FIN  = 2'd2
   } rule_state_e;

endpackage

// File: rtl/rule_dram_loader_if.sv
// Valid/ready rule word stream from the host/config path into the loader.
interface rule_dram_loader_if
   import rule_mem_pkg::*;
#(
   parameter int WORD_W = RULE_WORD_W
);
   logic              s_valid;
   logic              s_ready;
   logic [WORD_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/rule_word_unpacker.sv
// Shift buffer that splits stream words into entries, LS entry first, and
// raises ready early enough to overlap the next word with the last entry.
module rule_word_unpacker
   import rule_mem_pkg::*;
#(
   parameter int ENTRY_W = RULE_ENTRY_W,
   parameter int WORD_W  = RULE_WORD_W,
   parameter int CNT_W   = RULE_ADDR_W + 1,
   localparam int NIB    = WORD_W / ENTRY_W,
   localparam int NL_W   = $clog2(NIB + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               accept,
   input  logic [WORD_W-1:0]  data,
   input  logic [CNT_W-1:0]   entries_left,
   input  logic               run,
   input  logic               more,
   output logic               ready,
   output logic [NL_W-1:0]    nib_left,
   output logic [ENTRY_W-1:0] wdata
);
   logic [WORD_W-1:0] buffer;
   logic [NL_W-1:0]   take;
   logic [NL_W-1:0]   nib_left_n;

   // The accepted word's first entry is written in the accept cycle itself,
   // so only the remaining entries are counted in nib_left.
   always_comb begin
      take       = (entries_left >= CNT_W'(NIB)) ? NL_W'(NIB) : NL_W'(entries_left);
      nib_left_n = nib_left;
      if (accept)
         nib_left_n = take - NL_W'(1);
      else if (nib_left != '0)
         nib_left_n = nib_left - NL_W'(1);
      wdata = accept ? data[ENTRY_W-1:0] : buffer[ENTRY_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buffer   <= '0;
         nib_left <= '0;
         ready    <= 1'b0;
      end else begin
         nib_left <= nib_left_n;
         ready    <= run && more && (nib_left_n == '0);
         if (accept)
            buffer <= data >> ENTRY_W;
         else if (nib_left != '0)
            buffer <= buffer >> ENTRY_W;
      end
   end
endmodule

// File: rtl/rule_dram_loader.sv
// Write-side engine for the rule memory: unpacks stream words into entries.
// Optional RULE_LOADER_CHECKSUM_EN adds a 16-bit sum of written entries.
//
// state | meaning
// IDLE  | waiting for start; config sampled here
// LOAD  | accepting words and writing one entry per cycle
// FIN   | one cycle to issue done and publish err_cfg
module rule_dram_loader
   import rule_mem_pkg::*;
#(
   parameter int ADDR_W  = RULE_ADDR_W,
   parameter int ENTRY_W = RULE_ENTRY_W,
   parameter int WORD_W  = RULE_WORD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [ADDR_W:0]    num_entries,
   rule_dram_loader_if.slave  s_if,
   output logic               busy,
   output logic               done,
   output logic               err_cfg,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [ENTRY_W-1:0] mem_din
`ifdef RULE_LOADER_CHECKSUM_EN
   ,
   output logic [15:0]        checksum
`else
`endif
);
   localparam int NIB  = WORD_W / ENTRY_W;
   localparam int NL_W = $clog2(NIB + 1);
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   rule_state_e        state;
   logic [ADDR_W-1:0]  cur_addr;
   logic [ADDR_W:0]    entries_left;
   logic [ADDR_W:0]    words_left;
   logic [ADDR_W:0]    words_nxt;
   logic [ADDR_W:0]    words_init;
   logic [ADDR_W+1:0]  num_ext;
   logic               err_pend;
   logic               cfg_big, cfg_ok;
   logic               accept, wr, last_wr, run, more, rdy;
   logic [NL_W-1:0]    nib_left;
   logic [ENTRY_W-1:0] wdata;

   assign num_ext    = {1'b0, num_entries} + (ADDR_W+2)'(NIB - 1);
   assign words_init = (ADDR_W+1)'(num_ext / (ADDR_W+2)'(NIB));
   assign cfg_big    = num_entries > DEPTH;
   assign cfg_ok     = (num_entries != '0) && !cfg_big;
   assign accept     = (state == LOAD) && s_if.s_valid && rdy;
   assign wr         = accept || (nib_left != '0);
   assign last_wr    = (state == LOAD) && wr && (entries_left == (ADDR_W+1)'(1));
   assign more       = (words_nxt != '0);
   assign s_if.s_ready = rdy;

   always_comb begin
      words_nxt = words_left;
      run       = 1'b0;
      case (state)
         IDLE: begin
            words_nxt = words_init;
            run       = start && cfg_ok;
         end
         LOAD: begin
            words_nxt = words_left - (ADDR_W+1)'(accept);
            run       = !last_wr;
         end
         default: ;
      endcase
   end

   rule_word_unpacker #(
      .ENTRY_W (ENTRY_W),
      .WORD_W  (WORD_W),
      .CNT_W   (ADDR_W + 1)
   ) u_unpacker (
      .clk          (clk),
      .rst          (rst),
      .accept       (accept),
      .data         (s_if.s_data),
      .entries_left (entries_left),
      .run          (run),
      .more         (more),
      .ready        (rdy),
      .nib_left     (nib_left),
      .wdata        (wdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cur_addr     <= '0;
         entries_left <= '0;
         words_left   <= '0;
         err_pend     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_cfg      <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
`ifdef RULE_LOADER_CHECKSUM_EN
         checksum     <= '0;
`endif
      end else begin
         done   <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cur_addr     <= base_addr;
                  entries_left <= num_entries;
                  words_left   <= words_nxt;
                  err_pend     <= cfg_big;
                  err_cfg      <= 1'b0;
                  busy         <= 1'b1;
`ifdef RULE_LOADER_CHECKSUM_EN
                  checksum     <= '0;
`endif
                  state        <= cfg_ok ? LOAD : FIN;
               end
            end
            LOAD: begin
               words_left <= words_nxt;
               if (wr) begin
                  mem_en       <= 1'b1;
                  mem_we       <= 1'b1;
                  mem_addr     <= cur_addr;
                  mem_din      <= wdata;
                  cur_addr     <= cur_addr + ADDR_W'(1);
                  entries_left <= entries_left - (ADDR_W+1)'(1);
`ifdef RULE_LOADER_CHECKSUM_EN
                  checksum     <= checksum + 16'(wdata);
`endif
               end
               if (last_wr)
                  state <= FIN;
            end
            FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               err_cfg <= err_pend;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rule_dram_loader.sv
// Directed, table-driven bench for rule_dram_loader plus reset/start corner sequences.
module tb_rule_dram_loader;
   import rule_mem_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [14:0] base_addr;
   logic [15:0] num_entries;
   logic        busy, done, err_cfg, mem_en, mem_we;
   logic [14:0] mem_addr;
   logic [3:0]  mem_din;
`ifdef RULE_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   rule_dram_loader_if #(.WORD_W(32)) s_if ();

   rule_dram_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .num_entries (num_entries),
      .s_if        (s_if.slave),
      .busy        (busy),
      .done        (done),
      .err_cfg     (err_cfg),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din)
`ifdef RULE_LOADER_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] base;
      logic [15:0] num;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      int          nwords;
      int          vmode;
      bit          glitch;
      int          exp_writes;
      int          exp_words;
      bit          exp_err;
      bit          exp_contig;
      logic [15:0] exp_sum;
   } vec_t;

   vec_t  vt [9];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    nw = 0;
   logic [14:0] wa [64];
   logic [3:0]  wd [64];
   int          wc [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (mem_en) begin
         chk("mem_we_eq_en", {31'd0, mem_we}, 32'd1);
         if (nw < 64) begin
            wa[nw] = mem_addr;
            wd[nw] = mem_din;
            wc[nw] = cyc;
         end
         nw++;
      end
   endtask

   function automatic logic [31:0] pick(input vec_t v, input int idx);
      if (idx == 0) return v.w0;
      if (idx == 1) return v.w1;
      return v.w2;
   endfunction

   task automatic run_vec(input vec_t v, input int id);
      int   idx;
      bit   fire, got;
      int   done_cyc;
      logic err_at, rdy_at, busy_at;
      logic [31:0] word;
      idx = 0; got = 0; done_cyc = 0;
      err_at = 1'b0; rdy_at = 1'b1; busy_at = 1'b1;
      nw = 0;
      base_addr   = v.base;
      num_entries = v.num;
      s_if.s_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         s_if.s_valid = (idx < v.nwords) && (v.vmode == 0 || ((k / 3) % 2 == 0));
         s_if.s_data  = pick(v, idx);
         fire = s_if.s_valid && s_if.s_ready;
         if (v.glitch && k == 1) begin
            start       = 1'b1;
            base_addr   = 15'h0500;
            num_entries = 16'd3;
         end
         tick();
         start = 1'b0;
         if (fire) idx++;
         if (done) begin
            got = 1; done_cyc = cyc;
            err_at = err_cfg; rdy_at = s_if.s_ready; busy_at = busy;
         end
      end
      s_if.s_valid = 1'b0;
      chk($sformatf("v%0d_done_seen", id), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_writes", id), nw, v.exp_writes);
      chk($sformatf("v%0d_words_taken", id), idx, v.exp_words);
      chk($sformatf("v%0d_err_cfg", id), {31'd0, err_at}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_busy_at_done", id), {31'd0, busy_at}, 32'd0);
      chk($sformatf("v%0d_ready_at_done", id), {31'd0, rdy_at}, 32'd0);
      for (int i = 0; i < nw && i < 64; i++) begin
         word = pick(v, i / 8);
         chk($sformatf("v%0d_addr%0d", id, i), {17'd0, wa[i]}, {17'd0, 15'(v.base + 15'(i))});
         chk($sformatf("v%0d_din%0d", id, i), {28'd0, wd[i]}, {28'd0, 4'((word >> (4 * (i % 8))) & 32'hF)});
      end
      if (nw > 0 && got)
         chk($sformatf("v%0d_done_latency", id), done_cyc - wc[nw-1], 32'd1);
      if (v.exp_contig && nw > 0)
         chk($sformatf("v%0d_contiguous", id), wc[nw-1] - wc[0], nw - 1);
`ifdef RULE_LOADER_CHECKSUM_EN
      chk($sformatf("v%0d_checksum", id), {16'd0, checksum}, {16'd0, v.exp_sum});
`endif
      tick();
      chk($sformatf("v%0d_done_pulse", id), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_err_hold", id), {31'd0, err_cfg}, {31'd0, v.exp_err});
      tick();
   endtask

   initial begin
      bit fire;
      vt[0] = '{15'h0010, 16'd8,      32'h76543210, 32'h0,        32'h0,        1, 0, 1'b0, 8,  1, 1'b0, 1'b1, 16'd28};
      vt[1] = '{15'h7FFE, 16'd4,      32'h0000DCBA, 32'h0,        32'h0,        1, 0, 1'b0, 4,  1, 1'b0, 1'b1, 16'd46};
      vt[2] = '{15'h0100, 16'd10,     32'h11111111, 32'hFFFFFF22, 32'hAAAAAAAA, 3, 0, 1'b0, 10, 2, 1'b0, 1'b1, 16'd12};
      vt[3] = '{15'h2000, 16'd16,     32'h89ABCDEF, 32'h01234567, 32'h0,        2, 0, 1'b0, 16, 2, 1'b0, 1'b1, 16'd120};
      vt[4] = '{15'h3000, 16'd16,     32'h89ABCDEF, 32'h01234567, 32'h0,        2, 1, 1'b0, 16, 2, 1'b0, 1'b0, 16'd120};
      vt[5] = '{15'h0200, 16'd0,      32'h12345678, 32'h0,        32'h0,        1, 0, 1'b0, 0,  0, 1'b0, 1'b0, 16'd0};
      vt[6] = '{15'h0300, 16'h8001,   32'h12345678, 32'h0,        32'h0,        1, 0, 1'b0, 0,  0, 1'b1, 1'b0, 16'd0};
      vt[7] = '{15'h7FFF, 16'd3,      32'h00000FED, 32'h0,        32'h0,        1, 0, 1'b0, 3,  1, 1'b0, 1'b1, 16'd42};
      vt[8] = '{15'h0040, 16'd8,      32'hFEDCBA98, 32'h0,        32'h0,        1, 0, 1'b1, 8,  1, 1'b0, 1'b1, 16'd92};

      rst = 1'b1; start = 1'b0; base_addr = '0; num_entries = '0;
      s_if.s_valid = 1'b0; s_if.s_data = '0;
      tick(); tick();
      chk("rst_s_ready", {31'd0, s_if.s_ready}, 32'd0);
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_done",    {31'd0, done},    32'd0);
      chk("rst_err_cfg", {31'd0, err_cfg}, 32'd0);
      chk("rst_mem_en",  {31'd0, mem_en},  32'd0);
      chk("rst_mem_we",  {31'd0, mem_we},  32'd0);
      chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
      chk("rst_mem_din",  {28'd0, mem_din},  32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++)
         run_vec(vt[i], i);

      // Reset in the middle of a load after three entries were written.
      nw = 0;
      base_addr = 15'h0050; num_entries = 16'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      s_if.s_data = 32'h76543210;
      s_if.s_valid = 1'b1;
      for (int k = 0; k < 20 && nw < 3; k++) begin
         fire = s_if.s_valid && s_if.s_ready;
         tick();
         if (fire) s_if.s_valid = 1'b0;
      end
      chk("rst_mid_reach3", nw, 32'd3);
      chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rst_mid_mem_en",  {31'd0, mem_en},      32'd0);
      chk("rst_mid_busy",    {31'd0, busy},        32'd0);
      chk("rst_mid_s_ready", {31'd0, s_if.s_ready}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("rst_mid_total_writes", nw, 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_mid_addr%0d", i), {17'd0, wa[i]}, 32'h50 + i);
         chk($sformatf("rst_mid_din%0d", i),  {28'd0, wd[i]}, i);
      end
      chk("rst_mid_idle_busy", {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
